// File: rtl/rr_finder_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one single-port resource.
// The winner is the first requester found scanning upward from a rotating
// pointer. A grant is held until its owner drops its request or until it
// has been held for MAX_HOLD cycles. Every grant is followed by one idle
// cycle before the next grant.
module rr_finder_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNTW     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CNTW-1:0] hold_cnt;

    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic            found;
    logic [N-1:0]    win_onehot;
    logic            owner_drop;
    logic            hold_expired;

    // Rotating-priority search: first set request at ptr, ptr+1, ... (mod N).
    always_comb begin
        win   = ptr;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr + IW'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
    end

    // Release conditions; a drop on the expiry edge is a normal release.
    always_comb begin
        owner_drop   = !req[gnt_idx];
        hold_expired = (MAX_HOLD != 0) && (hold_cnt == CNTW'(MAX_HOLD));
    end

    // Grant FSM with registered outputs; timeout is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= win_onehot;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CNTW'(1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (owner_drop || hold_expired) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IW'(1);
                        state     <= IDLE;
                        timeout   <= !owner_drop;
                    end else begin
                        hold_cnt <= hold_cnt + CNTW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_finder_arbiter.sv
// Self-checking bench for rr_finder_arbiter: directed steps feed a behavioural
// model whose per-cycle expectations are queued and compared after each edge.
module tb_rr_finder_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_pass;
    int n_checks;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t sb[$];

    // Behavioural reference state
    bit m_busy;
    int m_ptr;
    int m_idx;
    int m_cnt;
    int m_last_idx;
    bit m_to;

    rr_finder_arbiter #(
        .N(8),
        .MAX_HOLD(16),
        .CNTW(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Advance the reference model by one rising edge.
    task automatic model_edge(input logic [7:0] r, input logic rs);
        m_to = 1'b0;
        if (rs) begin
            m_busy = 1'b0; m_ptr = 0; m_cnt = 0; m_last_idx = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && r[(m_ptr + k) % 8]) begin
                    m_busy = 1'b1;
                    m_idx = (m_ptr + k) % 8;
                    m_last_idx = m_idx;
                    m_cnt = 1;
                end
            end
        end else if (r[m_idx] == 1'b0) begin
            m_busy = 1'b0;
            m_ptr = (m_idx + 1) % 8;
        end else if (m_cnt == 16) begin
            m_busy = 1'b0;
            m_ptr = (m_idx + 1) % 8;
            m_to = 1'b1;
        end else begin
            m_cnt++;
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic step(input logic [7:0] r, input logic rs);
        exp_t e;
        @(negedge clk);
        req = r;
        reset = rs;
        model_edge(r, rs);
        e.gnt   = m_busy ? (8'h01 << m_idx) : 8'h00;
        e.idx   = 3'(m_last_idx);
        e.valid = m_busy;
        e.to    = m_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("gnt", gnt, e.gnt);
        check("gnt_idx", {5'b0, gnt_idx}, {5'b0, e.idx});
        check("gnt_valid", {7'b0, gnt_valid}, {7'b0, e.valid});
        check("timeout", {7'b0, timeout}, {7'b0, e.to});
        check("onehot", {7'b0, $countones(gnt) <= 1}, 8'h01);
    endtask

    initial begin
        int rises;
        int tos;
        int run;
        int exp_idx;
        bit prev_v;

        n_pass = 0;
        n_checks = 0;
        req = 8'h00;
        reset = 1'b1;
        m_busy = 0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_last_idx = 0; m_to = 0;

        // Reset then idle
        step(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0);
        check("idle_gnt", gnt, 8'h00);

        // Requesters 2 and 5; 2 drops after 3 grant cycles
        step(8'h24, 1'b0);
        check("first_grant", gnt, 8'h04);
        step(8'h24, 1'b0);
        step(8'h24, 1'b0);
        step(8'h20, 1'b0);
        check("bubble", gnt, 8'h00);
        step(8'h20, 1'b0);
        check("second_grant", gnt, 8'h20);
        check("second_idx", {5'b0, gnt_idx}, 8'd5);
        step(8'h00, 1'b0);

        // All requesting: strict rotation with timeouts
        step(8'hFF, 1'b1);
        rises = 0; tos = 0; run = 0; exp_idx = 0; prev_v = 0;
        for (int i = 0; i < 137; i++) begin
            step(8'hFF, 1'b0);
            if (gnt_valid && !prev_v) begin
                check("rotation_idx", {5'b0, gnt_idx}, 8'(exp_idx));
                exp_idx = (exp_idx + 1) % 8;
                rises++;
            end
            if (gnt_valid) run++;
            if (!gnt_valid && prev_v) begin
                check("hold_len", 8'(run), 8'd16);
                run = 0;
            end
            if (timeout) tos++;
            prev_v = gnt_valid;
        end
        check("grant_count", 8'(rises), 8'd9);
        check("timeout_count", 8'(tos), 8'd8);

        // Pointer wrap from 7 to 0
        step(8'h00, 1'b1);
        step(8'h80, 1'b0);
        check("grant7", gnt, 8'h80);
        step(8'h00, 1'b0);
        step(8'h81, 1'b0);
        check("wrap_idx", {5'b0, gnt_idx}, 8'd0);
        step(8'h00, 1'b0);

        // Drop coinciding with hold expiry is a normal release
        step(8'h00, 1'b1);
        step(8'h08, 1'b0);
        for (int i = 0; i < 15; i++) step(8'h08, 1'b0);
        check("still_held", gnt, 8'h08);
        step(8'h00, 1'b0);
        check("simul_timeout", {7'b0, timeout}, 8'h00);
        check("simul_gnt", gnt, 8'h00);
        step(8'h09, 1'b0);
        check("ptr_after_simul", {5'b0, gnt_idx}, 8'd0);
        step(8'h00, 1'b0);

        // Reset mid-grant
        step(8'h00, 1'b1);
        step(8'h10, 1'b0);
        for (int i = 0; i < 4; i++) step(8'hFF, 1'b0);
        check("pre_reset_gnt", gnt, 8'h10);
        step(8'hFF, 1'b1);
        check("reset_gnt", gnt, 8'h00);
        check("reset_timeout", {7'b0, timeout}, 8'h00);
        step(8'hFF, 1'b0);
        check("post_reset_gnt", gnt, 8'h01);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step(8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)), ($urandom_range(0, 63) == 0));
        end

        check("sb_empty", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_finder_arbiter.md
Name: rr_finder_arbiter

Overview:
Round-robin arbiter granting one shared resource to one of 8 requesters. It uses a rotating-priority lowest-index search starting at a moving pointer. Grants are held until the owner drops its request, or until a hold-time limit forces preemption. It sits in front of any single-port shared unit (memory port, bus, ALU) and drives that unit's select.

Parameters:
N, 8, number of requesters (fixed at 8 for this revision; index width is 3)
MAX_HOLD, 16, max consecutive cycles one grant may be held; 0 disables timeout
CNTW, 5, hold-counter width; must satisfy 2^CNTW > MAX_HOLD

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  8  request vector, bit i = requester i wants the resource; level-sensitive
gnt  output  8  one-hot grant, registered; all-zero when idle
gnt_idx  output  3  binary index of current grant, registered; holds last granted index when idle
gnt_valid  output  1  high while any grant is active (equals OR of gnt)
timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD

Behaviour:
- One clock, reset is synchronous and active-high: on a rising clk edge with reset=1, all state clears. After that edge:
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0
  - ptr=3'd0, hold_cnt=0, state=IDLE
- Reset overrides all other activity, including an active grant. The grant drops on the edge that samples reset=1, with no timeout pulse.
- Internal state: 2-state FSM {IDLE, BUSY}; 3-bit ptr; CNTW-bit hold_cnt.
- IDLE:
  - If req==0: stay IDLE, outputs unchanged (gnt=0).
  - Else select winner w = first set bit scanning indices ptr, ptr+1, ..., ptr+7 (mod 8).
  - Next edge: gnt=1<<w, gnt_idx=w, gnt_valid=1, hold_cnt=1, state=BUSY.
  - Latency: request sampled at edge k means grant visible after edge k+1 (one cycle).
- BUSY, evaluated each edge:
  - Release if req[gnt_idx]==0. In that case: gnt=0, gnt_valid=0, ptr=gnt_idx+1 (mod 8, so 7 wraps to 0), state=IDLE, timeout=0.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD: forced release with the same updates, but timeout=1 for exactly one cycle.
  - Else: hold the grant and increment hold_cnt. Requests from other requesters are ignored.
- A grant lasts at most MAX_HOLD cycles.
- Between any two grants there is exactly one idle cycle with gnt=0. There is no back-to-back handover.
- Simultaneous drop of req[gnt_idx] and hold_cnt==MAX_HOLD counts as a normal release: timeout=0.
- A preempted requester that keeps req high loses priority because ptr moves past it. It is re-granted immediately after the bubble only if it is the sole requester.
- timeout is cleared to 0 on every edge where it is not being set.
- gnt is always one-hot or zero. gnt_idx is stable throughout a grant.
- Fairness: with all 8 requesting continuously, grants cycle 0,1,...,7,0 in strict order.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 every cycle.
- After reset, req=8'b0010_0100 held; requester 2 drops after 3 grant cycles -> gnt=8'h04 one cycle after req for 3 cycles, one idle cycle, then gnt=8'h20, gnt_idx=5.
- req=8'hFF held continuously, MAX_HOLD=16 -> each grant lasts 16 cycles with timeout pulse at each revoke; gnt_idx sequence 0,1,2,...,7,0; one gnt=0 cycle between grants.
- ptr wrap: grant requester 7, release, then req=8'b1000_0001 -> next grant is gnt_idx=0, not 7.
- Simultaneous: hold requester 3 exactly until cycle 16, dropping req[3] on the same edge hold_cnt==16 -> release with timeout=0, ptr=4.
- Reset asserted mid-grant (gnt=8'h10, hold_cnt=5) while req=8'hFF -> next cycle gnt=0, ptr=0; release reset -> grant to index 0 one cycle later.
